// File: rtl/rbs_10bit_serial.sv
// rtl/rbs_10bit_serial.sv - bit-serial ripple-borrow subtractor, one full-subtractor stage per clock
//
// Computes i_sub_term1 - i_sub_term2 (unsigned), LSB first, over WIDTH cycles.
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_valid      operand pair valid (sampled in IDLE only)
//   o_in_ready   high while IDLE
//   i_sub_term1  minuend A
//   i_sub_term2  subtrahend B
//   o_valid      high while DONE
//   i_ready      downstream accepts o_result
//   o_result     {borrow_out, A-B mod 2^WIDTH}

module rbs_10bit_serial #(
    parameter int WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_sub_term1,
    input  logic [WIDTH-1:0] i_sub_term2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic a_bit;
    logic b_bit;
    logic d_bit;
    logic bout;
    logic last_bit;

    // The single full-subtractor cell, always fed from the operand LSBs.
    assign a_bit    = a_sh[0];
    assign b_bit    = b_sh[0];
    assign d_bit    = a_bit ^ b_bit ^ borrow;
    assign bout     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Handshake outputs decode straight from the state register, so no input
    // reaches them combinationally.
    assign o_in_ready = (state == IDLE);
    assign o_valid    = (state == DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid)  state_nxt = BUSY;
            BUSY:    if (last_bit) state_nxt = DONE;
            DONE:    if (i_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            diff_sh  <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            o_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_sh   <= i_sub_term1;
                        b_sh   <= i_sub_term2;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    // Difference bits enter at the MSB so bit 0 ends up at bit 0.
                    diff_sh <= {d_bit, diff_sh[WIDTH-1:1]};
                    borrow  <= bout;
                    if (last_bit) begin
                        o_result <= {bout, d_bit, diff_sh[WIDTH-1:1]};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rbs_10bit_serial.sv
// tb/tb_rbs_10bit_serial.sv - self-checking bench for rbs_10bit_serial

module tb_rbs_10bit_serial;

    localparam int WIDTH = 10;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_in_ready;
    logic [WIDTH-1:0] i_sub_term1;
    logic [WIDTH-1:0] i_sub_term2;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH:0]   o_result;

    int checks = 0;
    int errors = 0;

    rbs_10bit_serial #(.WIDTH(WIDTH)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_in_ready  (o_in_ready),
        .i_sub_term1 (i_sub_term1),
        .i_sub_term2 (i_sub_term2),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // One full transaction: accept, wait for DONE (checking latency), optionally
    // hold backpressure, then release and check the return to IDLE.
    task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH:0] exp, input int hold,
                           input bit interfere, input string name);
        int lat;
        bit stable;
        @(negedge i_clk);
        check({name, " in_ready"}, 32'(o_in_ready), 32'd1);
        i_valid     = 1'b1;
        i_sub_term1 = a;
        i_sub_term2 = b;
        @(negedge i_clk);
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 40) begin
            if (interfere) begin
                i_valid     = 1'($urandom_range(0, 1));
                i_ready     = 1'($urandom_range(0, 1));
                i_sub_term1 = WIDTH'($urandom);
                i_sub_term2 = WIDTH'($urandom);
            end
            @(negedge i_clk);
            lat++;
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(WIDTH));
        check({name, " result"}, 32'(o_result), 32'(exp));
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge i_clk);
                if (o_valid !== 1'b1 || o_result !== exp || o_in_ready !== 1'b0)
                    stable = 1'b0;
            end
            check({name, " hold stable"}, 32'(stable), 32'd1);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        check({name, " back to idle"}, {30'd0, o_valid, o_in_ready}, 32'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH:0]   rexp;

        vecs[0] = '{a: 10'd700,  b: 10'd300,  exp: 11'h190};
        vecs[1] = '{a: 10'd5,    b: 10'd10,   exp: 11'h7FB};
        vecs[2] = '{a: 10'd0,    b: 10'd0,    exp: 11'h000};
        vecs[3] = '{a: 10'd1023, b: 10'd1023, exp: 11'h000};
        vecs[4] = '{a: 10'd0,    b: 10'd1023, exp: 11'h401};
        vecs[5] = '{a: 10'd1023, b: 10'd0,    exp: 11'h3FF};
        vecs[6] = '{a: 10'd512,  b: 10'd511,  exp: 11'h001};
        vecs[7] = '{a: 10'd511,  b: 10'd512,  exp: 11'h7FF};
        vecs[8] = '{a: 10'd1,    b: 10'd0,    exp: 11'h001};
        vecs[9] = '{a: 10'h2AA,  b: 10'h155,  exp: 11'h155};

        i_rst_n     = 1'b0;
        i_valid     = 1'b0;
        i_ready     = 1'b0;
        i_sub_term1 = '0;
        i_sub_term2 = '0;
        repeat (3) @(negedge i_clk);
        check("reset in_ready", 32'(o_in_ready), 32'd1);
        check("reset valid", 32'(o_valid), 32'd0);
        check("reset result", 32'(o_result), 32'd0);
        i_rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_txn(vecs[i].a, vecs[i].b, vecs[i].exp, 0, 1'b0, $sformatf("vec%0d", i));

        // Backpressure: 20 cycles held in DONE.
        run_txn(10'd700, 10'd300, 11'h190, 20, 1'b0, "backpressure");

        // Inputs and handshakes thrash while BUSY; the latched pair must win.
        run_txn(10'd5, 10'd10, 11'h7FB, 0, 1'b1, "interfere1");
        run_txn(10'd1000, 10'd999, 11'h001, 2, 1'b1, "interfere2");

        // Reset during bit 5 of an operation.
        @(negedge i_clk);
        i_valid     = 1'b1;
        i_sub_term1 = 10'd700;
        i_sub_term2 = 10'd300;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (5) @(negedge i_clk);
        #1 i_rst_n = 1'b0;
        #1;
        check("midreset valid", 32'(o_valid), 32'd0);
        check("midreset in_ready", 32'(o_in_ready), 32'd1);
        check("midreset result", 32'(o_result), 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_txn(10'd123, 10'd456, 11'h6B3, 0, 1'b0, "after reset");

        // Random pairs with random idle gaps and backpressure.
        for (int n = 0; n < 300; n++) begin
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rexp = {1'b0, ra} - {1'b0, rb};
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
            run_txn(ra, rb, rexp, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
